// File: rtl/avg_scheduler_pkg.sv
// Shared types and constants for the channel-averager scheduler.
package glue_pkg;

    localparam int NUM_CH   = 16;
    localparam int SAMPLE_W = 32;
    localparam int AVG_LOG2 = 3;
    localparam int CRC_W    = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        READ    = 2'd2,
        PRESENT = 2'd3
    } sched_state_t;

    // Sample of channel ch from a flat sample buffer, ch0 in the MSBs.
    function automatic logic [SAMPLE_W-1:0] sample_slice(
        input logic [NUM_CH*SAMPLE_W-1:0] pbuf,
        input logic [$clog2(NUM_CH)-1:0]  ch
    );
        logic [SAMPLE_W-1:0] s;
        s = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if ($clog2(NUM_CH)'(k) == ch)
                s = pbuf[(NUM_CH-1-k)*SAMPLE_W +: SAMPLE_W];
        end
        return s;
    endfunction

endpackage

// File: rtl/avg_scheduler_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    // Count up on i_inc, hold at all-ones.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            r_cnt <= '0;
        else if (i_inc && (r_cnt != '1))
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/avg_scheduler.sv
// Feeds latched packets channel by channel into the shared averager, and after a
// full averaging window collects every channel's result into one output frame.
module avg_scheduler
    import glue_pkg::*;
#(
    parameter int NUM_CH   = glue_pkg::NUM_CH,
    parameter int SAMPLE_W = glue_pkg::SAMPLE_W,
    parameter int AVG_LOG2 = glue_pkg::AVG_LOG2,
    parameter int PKT_W    = NUM_CH*SAMPLE_W + glue_pkg::CRC_W
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic                        i_pkt_valid,
    input  logic [PKT_W-1:0]            i_pkt_data,
    output logic                        o_pkt_ack,
    output logic                        o_avg_req,
    output logic [$clog2(NUM_CH)-1:0]   o_avg_ch,
    output logic [SAMPLE_W-1:0]         o_avg_sample,
    output logic                        o_avg_clear,
    input  logic                        i_avg_gnt,
    output logic                        o_res_req,
    output logic [$clog2(NUM_CH)-1:0]   o_res_ch,
    input  logic                        i_res_valid,
    input  logic [SAMPLE_W-1:0]         i_res_data,
    output logic                        o_out_valid,
    output logic [NUM_CH*SAMPLE_W-1:0]  o_out_data,
    input  logic                        i_out_ack,
    output logic                        o_busy,
    output logic [7:0]                  o_drop_cnt
);

    localparam int CH_W = $clog2(NUM_CH);

    sched_state_t r_state, w_next;
    logic [CH_W-1:0]                  r_ch;
    logic [AVG_LOG2-1:0]              r_pkt_cnt;
    // Element NUM_CH-1 holds channel 0 so the packed layout matches the bus
    // order; channel ch therefore lives at index ~ch (NUM_CH is a power of two).
    logic [NUM_CH-1:0][SAMPLE_W-1:0]  r_buf;
    logic [NUM_CH-1:0][SAMPLE_W-1:0]  r_out;

    logic              w_last_ch;
    logic              w_win_end;
    logic              w_drop;
    logic [CRC_W-1:0]  w_crc_unused;

    assign w_last_ch    = (r_ch == CH_W'(NUM_CH-1));
    assign w_win_end    = &r_pkt_cnt;
    assign w_drop       = i_pkt_valid && (r_state != IDLE);
    // CRC was already checked upstream; only the samples are kept.
    assign w_crc_unused = i_pkt_data[CRC_W-1:0];

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_pkt_valid) w_next = ISSUE;
            ISSUE:   if (i_avg_gnt && w_last_ch) w_next = w_win_end ? READ : IDLE;
            READ:    if (i_res_valid && w_last_ch) w_next = PRESENT;
            PRESENT: if (i_out_ack) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Packet latch, channel pointer, window counter and result gathering.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_ch      <= '0;
            r_pkt_cnt <= '0;
            r_buf     <= '0;
            r_out     <= '0;
        end else begin
            case (r_state)
                IDLE: if (i_pkt_valid) begin
                    r_buf <= i_pkt_data[PKT_W-1:CRC_W];
                    r_ch  <= '0;
                end
                ISSUE: if (i_avg_gnt) begin
                    if (w_last_ch) begin
                        r_ch      <= '0;
                        r_pkt_cnt <= r_pkt_cnt + 1'b1;
                    end else begin
                        r_ch <= r_ch + 1'b1;
                    end
                end
                READ: if (i_res_valid) begin
                    r_out[~r_ch] <= i_res_data;
                    r_ch         <= w_last_ch ? '0 : r_ch + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Per-state handshake outputs; request fields read zero when not requesting.
    always_comb begin
        o_pkt_ack    = 1'b0;
        o_avg_req    = 1'b0;
        o_avg_ch     = '0;
        o_avg_sample = '0;
        o_avg_clear  = 1'b0;
        o_res_req    = 1'b0;
        o_res_ch     = '0;
        o_out_valid  = 1'b0;
        case (r_state)
            IDLE:    o_pkt_ack = i_pkt_valid;
            ISSUE: begin
                o_avg_req    = 1'b1;
                o_avg_ch     = r_ch;
                o_avg_sample = r_buf[~r_ch];
                o_avg_clear  = (r_pkt_cnt == '0);
            end
            READ: begin
                o_res_req = 1'b1;
                o_res_ch  = r_ch;
            end
            PRESENT: o_out_valid = 1'b1;
            default: ;
        endcase
    end

    assign o_busy     = (r_state != IDLE);
    assign o_out_data = r_out;

    sat_counter #(.W(8)) u_drop_cnt (
        .clk   (clk),
        .n_rst (n_rst),
        .i_inc (w_drop),
        .o_cnt (o_drop_cnt)
    );

endmodule

// File: tb/tb_avg_scheduler.sv
// Bench for avg_scheduler: directed table, hand sequences, randomized run
// against a queue-based transaction model.
module tb_avg_scheduler;
    import glue_pkg::*;

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int FR_W  = NUM_CH*SAMPLE_W;
    localparam int PKT_W = FR_W + CRC_W;
    localparam int WIN   = 1 << AVG_LOG2;

    logic                 clk, n_rst;
    logic                 pv, gnt, rv, oack;
    logic [PKT_W-1:0]     pkt_data;
    logic [SAMPLE_W-1:0]  rdata;
    logic                 o_pkt_ack, o_avg_req, o_avg_clear, o_res_req, o_out_valid, o_busy;
    logic [CH_W-1:0]      o_avg_ch, o_res_ch;
    logic [SAMPLE_W-1:0]  o_avg_sample;
    logic [FR_W-1:0]      o_out_data;
    logic [7:0]           o_drop_cnt;

    avg_scheduler dut (
        .clk(clk), .n_rst(n_rst),
        .i_pkt_valid(pv), .i_pkt_data(pkt_data), .o_pkt_ack(o_pkt_ack),
        .o_avg_req(o_avg_req), .o_avg_ch(o_avg_ch), .o_avg_sample(o_avg_sample),
        .o_avg_clear(o_avg_clear), .i_avg_gnt(gnt),
        .o_res_req(o_res_req), .o_res_ch(o_res_ch), .i_res_valid(rv), .i_res_data(rdata),
        .o_out_valid(o_out_valid), .o_out_data(o_out_data), .i_out_ack(oack),
        .o_busy(o_busy), .o_drop_cnt(o_drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [53:0] outs = {o_pkt_ack, o_avg_req, o_avg_ch, o_avg_sample, o_avg_clear,
                        o_res_req, o_res_ch, o_out_valid, o_busy, o_drop_cnt};

    int n_vec = 0;
    int n_mis = 0;

    task automatic chk(input string nm, input logic [FR_W-1:0] act, input logic [FR_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [PKT_W-1:0] rnd_pkt();
        logic [PKT_W-1:0] p;
        for (int i = 0; i < PKT_W/16; i++) p[i*16 +: 16] = 16'($urandom);
        return p;
    endfunction

    function automatic logic [PKT_W-1:0] mk_pkt(input logic [31:0] base);
        logic [PKT_W-1:0] p;
        p = '0;
        for (int k = 0; k < NUM_CH; k++) p[PKT_W-1-k*SAMPLE_W -: SAMPLE_W] = base + 32'(k);
        p[CRC_W-1:0] = 16'hBEEF;
        return p;
    endfunction

    // One packet with gnt held high; ends on the first cycle with no request.
    task automatic send_pkt(input logic [PKT_W-1:0] d, input bit e_clr);
        int n;
        @(negedge clk); pv = 1'b1; pkt_data = d; gnt = 1'b1; #1;
        chk("pkt_ack", FR_W'({o_pkt_ack, o_busy}), FR_W'(2'b10));
        @(negedge clk); pv = 1'b0; pkt_data = rnd_pkt(); #1;
        chk("pkt_first", FR_W'({o_busy, o_avg_req, o_avg_ch, o_avg_sample, o_avg_clear}),
            FR_W'({1'b1, 1'b1, 4'd0, d[PKT_W-1 -: SAMPLE_W], e_clr}));
        n = 0;
        while (o_avg_req && n < 64) begin @(negedge clk); #1; n++; end
        chk("pkt_done", FR_W'(o_avg_req), '0);
    endtask

    typedef struct {
        bit pv; bit gnt; bit e_ack; bit e_req; int e_ch;
        logic [31:0] e_samp; bit e_clr; bit e_busy; int e_drop;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t row(bit p, bit g, bit a, bit r, int c, bit cl, bit b, int dr);
        vec_t v;
        v.pv = p; v.gnt = g; v.e_ack = a; v.e_req = r; v.e_ch = c;
        v.e_samp = r ? 32'h1000_0000 + 32'(c) : 32'h0;
        v.e_clr = cl; v.e_busy = b; v.e_drop = dr;
        return v;
    endfunction

    typedef struct { int ch; logic [31:0] s; bit clr; } iss_t;
    iss_t q[$];
    int   m_pkts, m_drops, m_rdch;
    bit   m_rd, m_pr;
    logic [31:0]      m_frame [NUM_CH];
    logic [PKT_W-1:0] pkt_a;
    logic [FR_W-1:0]  fr;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_rst = 1'b0; pv = 0; gnt = 0; rv = 0; oack = 0; rdata = '0; pkt_data = '0;
        pkt_a = mk_pkt(32'h1000_0000);

        // Reset and idle state.
        @(negedge clk); #1;
        chk("rst_outs", FR_W'(outs), '0);
        chk("rst_frame", o_out_data, '0);
        @(negedge clk); n_rst = 1'b1; #1;
        chk("idle_outs", FR_W'(outs), '0);

        // Packet A with gnt tied high, then packet B with a stall on ch5
        // and a dropped packet during ISSUE.
        tbl.push_back(row(1, 1, 1, 0, 0, 0, 0, 0));
        for (int k = 0; k < NUM_CH; k++) tbl.push_back(row(0, 1, 0, 1, k, 1, 1, 0));
        tbl.push_back(row(0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(row(1, 1, 1, 0, 0, 0, 0, 0));
        for (int k = 0; k < NUM_CH; k++) begin
            if (k == 5) for (int s = 0; s < 3; s++) tbl.push_back(row(0, 0, 0, 1, 5, 0, 1, 1));
            tbl.push_back(row(k == 2, 1, 0, 1, k, 0, 1, (k >= 3) ? 1 : 0));
        end
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 1));

        foreach (tbl[i]) begin
            @(negedge clk);
            pv = tbl[i].pv; gnt = tbl[i].gnt;
            pkt_data = tbl[i].e_ack ? pkt_a : rnd_pkt();
            #1;
            chk($sformatf("tbl[%0d]", i),
                FR_W'({o_pkt_ack, o_avg_req, o_avg_ch, o_avg_sample, o_avg_clear, o_busy, o_drop_cnt}),
                FR_W'({tbl[i].e_ack, tbl[i].e_req, 4'(tbl[i].e_ch), tbl[i].e_samp,
                       tbl[i].e_clr, tbl[i].e_busy, 8'(tbl[i].e_drop)}));
        end

        // Finish the window and read every result back.
        for (int p = 2; p < WIN; p++) send_pkt(rnd_pkt(), 1'b0);
        for (int c = 0; c < NUM_CH; c++) begin
            @(negedge clk); rv = 1'b0; rdata = $urandom; #1;
            chk("rd_req", FR_W'({o_res_req, o_res_ch, o_out_valid}), FR_W'({1'b1, 4'(c), 1'b0}));
            @(negedge clk); rv = 1'b1; rdata = 32'hA0 + 32'(c); #1;
        end
        for (int k = 0; k < NUM_CH; k++) fr[FR_W-1-k*SAMPLE_W -: SAMPLE_W] = 32'hA0 + 32'(k);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); rv = 1'b0; #1;
            chk("present", FR_W'({o_out_valid, o_busy, o_res_req}), FR_W'(3'b110));
            chk("frame", o_out_data, fr);
        end
        chk("frame_ch0", FR_W'(o_out_data[FR_W-1 -: SAMPLE_W]), FR_W'(32'hA0));
        chk("frame_ch15", FR_W'(o_out_data[SAMPLE_W-1:0]), FR_W'(32'hAF));

        // Drops during PRESENT saturate the counter.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); pv = 1'b1; pkt_data = rnd_pkt(); #1;
            chk("drop_noack", FR_W'({o_pkt_ack, o_out_valid}), FR_W'(2'b01));
            if (i == 100) chk("drop_mid", FR_W'(o_drop_cnt), FR_W'(8'd101));
        end
        @(negedge clk); pv = 1'b1; oack = 1'b1; #1;
        chk("ack_cycle", FR_W'({o_pkt_ack, o_out_valid, o_drop_cnt}), FR_W'({2'b01, 8'd255}));
        @(negedge clk); pv = 1'b0; oack = 1'b0; #1;
        chk("after_ack", FR_W'({o_out_valid, o_busy, o_drop_cnt}), FR_W'({2'b00, 8'd255}));

        // New window restarts the averager.
        send_pkt(rnd_pkt(), 1'b1);

        // Reset in the middle of READ.
        for (int p = 1; p < WIN; p++) send_pkt(rnd_pkt(), 1'b0);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk); rv = 1'b1; rdata = $urandom; #1;
        end
        @(negedge clk); rv = 1'b0; #1;
        chk("rd_ch7", FR_W'({o_res_req, o_res_ch}), FR_W'({1'b1, 4'd7}));
        @(negedge clk); n_rst = 1'b0; #1;
        chk("midrst_outs", FR_W'(outs), '0);
        chk("midrst_frame", o_out_data, '0);
        @(negedge clk); n_rst = 1'b1; #1;
        send_pkt(rnd_pkt(), 1'b1);

        // Randomized run against the transaction model.
        m_pkts = 1; m_drops = 0; m_rd = 0; m_pr = 0; m_rdch = 0; q.delete();
        for (int k = 0; k < NUM_CH; k++) m_frame[k] = '0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            bit e_busy, e_ack, e_req, e_clr;
            logic [31:0] e_s;
            int e_ch;
            iss_t it;
            @(negedge clk);
            pv = ($urandom_range(0, 99) < 15); pkt_data = rnd_pkt();
            gnt = ($urandom_range(0, 99) < 60); rv = 1'($urandom_range(0, 1));
            rdata = $urandom; oack = ($urandom_range(0, 99) < 30);
            #1;
            e_busy = (q.size() != 0) || m_rd || m_pr;
            e_ack  = pv && !e_busy;
            e_req  = (q.size() != 0);
            e_ch   = e_req ? q[0].ch : 0;
            e_s    = e_req ? q[0].s : 32'h0;
            e_clr  = e_req ? q[0].clr : 1'b0;
            chk("rnd", FR_W'(outs),
                FR_W'({e_ack, e_req, 4'(e_ch), e_s, e_clr, m_rd, 4'(m_rd ? m_rdch : 0),
                       m_pr, e_busy, 8'(m_drops)}));
            if (m_pr) begin
                for (int k = 0; k < NUM_CH; k++) fr[FR_W-1-k*SAMPLE_W -: SAMPLE_W] = m_frame[k];
                chk("rnd_frame", o_out_data, fr);
            end
            if (pv && e_busy && m_drops < 255) m_drops++;
            if (e_ack) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    it.ch = k; it.s = pkt_data[PKT_W-1-k*SAMPLE_W -: SAMPLE_W]; it.clr = (m_pkts == 0);
                    q.push_back(it);
                end
            end else if (e_req && gnt) begin
                it = q.pop_front();
                if (it.ch == NUM_CH-1) begin
                    m_pkts++;
                    if (m_pkts == WIN) begin m_pkts = 0; m_rd = 1; m_rdch = 0; end
                end
            end else if (m_rd && rv) begin
                m_frame[m_rdch] = rdata;
                m_rdch++;
                if (m_rdch == NUM_CH) begin m_rd = 0; m_pr = 1; end
            end else if (m_pr && oack) begin
                m_pr = 0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
